// File: rtl/apb_conduit_bridge_if.sv
// APB completer-side bus bundle for the conduit bridge.
// The master drives the request fields and the bridge drives the registered response.
interface apb_conduit_bridge_if #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 32
);
    logic [A_WIDTH-1:0]   paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [D_WIDTH-1:0]   pwdata;
    logic [D_WIDTH/8-1:0] pstrb;
    logic                 pready;
    logic [D_WIDTH-1:0]   prdata;
    logic                 pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_conduit_bridge.sv
// Multi-channel APB completer: decodes each transfer onto one conduit channel, issues a
// one-cycle request, waits for that channel's ack (or a timeout) and returns a registered response.
module apb_conduit_bridge #(
    parameter int D_WIDTH    = 32,
    parameter int A_WIDTH    = 12,
    parameter int NUM_CH     = 4,
    parameter int CH_A_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                      pclk,
    input  logic                      presetn,
    apb_conduit_bridge_if.slave       apb,
    output logic [NUM_CH-1:0]         con_wr,
    output logic [NUM_CH-1:0]         con_rd,
    output logic [CH_A_WIDTH-1:0]     con_addr,
    output logic [D_WIDTH-1:0]        con_wdata,
    output logic [D_WIDTH/8-1:0]      con_wstrb,
    input  logic [NUM_CH-1:0]         con_ack,
    input  logic [NUM_CH-1:0]         con_err,
    input  logic [NUM_CH*D_WIDTH-1:0] con_rdata,
    input  logic                      err_clr,
    output logic [7:0]                err_count
);

    localparam int CI_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HI_LSB = CH_A_WIDTH + CI_W;
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state;
    logic [CI_W-1:0]    ch_idx;
    logic [CI_W-1:0]    ch_q;
    logic               wr_q;
    logic [TW-1:0]      timer;
    logic               access;
    logic               dec_err;
    logic               ack_hit;
    logic               err_hit;
    logic               timed_out;
    logic [D_WIDTH-1:0] rdata_sel;

    assign ch_idx    = apb.paddr[CH_A_WIDTH +: CI_W];
    assign access    = (state == S_IDLE) && apb.psel && apb.penable;
    // Channel indices past NUM_CH and any address bit above the channel field are holes.
    assign dec_err   = ({1'b0, ch_idx} >= (CI_W + 1)'(NUM_CH)) ||
                       ((apb.paddr >> HI_LSB) != '0);
    assign ack_hit   = con_ack[ch_q];
    assign err_hit   = con_err[ch_q];
    assign rdata_sel = con_rdata[int'(ch_q) * D_WIDTH +: D_WIDTH];
    assign timed_out = (TIMEOUT != 0) && (timer == TIMER_LAST);

    assign con_addr  = apb.paddr[CH_A_WIDTH-1:0];
    assign con_wdata = apb.pwdata;
    assign con_wstrb = apb.pstrb;

    // Request pulses exist only in the first access cycle, which guarantees one outstanding request.
    always_comb begin
        con_wr = '0;
        con_rd = '0;
        if (presetn && access && !dec_err) begin
            if (apb.pwrite) begin
                con_wr = NUM_CH'(1) << ch_idx;
            end else begin
                con_rd = NUM_CH'(1) << ch_idx;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= S_IDLE;
            ch_q        <= '0;
            wr_q        <= 1'b0;
            timer       <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
        end else begin
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        ch_q  <= ch_idx;
                        wr_q  <= apb.pwrite;
                        timer <= '0;
                        if (dec_err) begin
                            state       <= S_RESP;
                            apb.pready  <= 1'b1;
                            apb.pslverr <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A master dropping psel mid-transfer abandons it; any later ack lands in IDLE.
                    if (!apb.psel) begin
                        state <= S_IDLE;
                    end else if (ack_hit) begin
                        state       <= S_RESP;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= err_hit;
                        if (!wr_q && !err_hit) begin
                            apb.prdata <= rdata_sel;
                        end
                    end else if (timed_out) begin
                        state       <= S_RESP;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= 8'd0;
        end else if ((state == S_RESP) && apb.pslverr && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_apb_conduit_bridge.sv
// Scoreboard bench for apb_conduit_bridge: a 4-channel and a 3-channel instance driven with
// directed APB transfers; expected responses are queued and checked when pready appears.
module tb_apb_conduit_bridge;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct packed {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic [11:0] paddr   = '0;
    logic        psel0   = 1'b0;
    logic        psel3   = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    logic        err_clr = 1'b0;

    logic [3:0]   con_wr0, con_rd0, con_wstrb0;
    logic [3:0]   con_ack0 = '0;
    logic [3:0]   con_err0 = '0;
    logic [7:0]   con_addr0, err_count0;
    logic [31:0]  con_wdata0;
    logic [127:0] con_rdata0 = '0;

    logic [2:0]   con_wr3, con_rd3;
    logic [3:0]   con_wstrb3;
    logic [2:0]   con_ack3 = '0;
    logic [2:0]   con_err3 = '0;
    logic [7:0]   con_addr3, err_count3;
    logic [31:0]  con_wdata3;
    logic [95:0]  con_rdata3 = '0;

    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q3[$];

    apb_conduit_bridge_if #(.A_WIDTH(AW), .D_WIDTH(DW)) apb ();
    apb_conduit_bridge_if #(.A_WIDTH(AW), .D_WIDTH(DW)) apb3 ();

    assign apb.paddr    = paddr;
    assign apb.psel     = psel0;
    assign apb.penable  = penable;
    assign apb.pwrite   = pwrite;
    assign apb.pwdata   = pwdata;
    assign apb.pstrb    = pstrb;
    assign apb3.paddr   = paddr;
    assign apb3.psel    = psel3;
    assign apb3.penable = penable;
    assign apb3.pwrite  = pwrite;
    assign apb3.pwdata  = pwdata;
    assign apb3.pstrb   = pstrb;

    apb_conduit_bridge #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_CH(4), .CH_A_WIDTH(8), .TIMEOUT(64)) dut (
        .pclk(pclk), .presetn(presetn), .apb(apb.slave),
        .con_wr(con_wr0), .con_rd(con_rd0), .con_addr(con_addr0), .con_wdata(con_wdata0),
        .con_wstrb(con_wstrb0), .con_ack(con_ack0), .con_err(con_err0), .con_rdata(con_rdata0),
        .err_clr(err_clr), .err_count(err_count0)
    );

    apb_conduit_bridge #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_CH(3), .CH_A_WIDTH(8), .TIMEOUT(64)) dut3 (
        .pclk(pclk), .presetn(presetn), .apb(apb3.slave),
        .con_wr(con_wr3), .con_rd(con_rd3), .con_addr(con_addr3), .con_wdata(con_wdata3),
        .con_wstrb(con_wstrb3), .con_ack(con_ack3), .con_err(con_err3), .con_rdata(con_rdata3),
        .err_clr(err_clr), .err_count(err_count3)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic monitorPort(input bit on3, input logic rdy, input logic err, input logic [31:0] data);
        exp_t e;
        if (!rdy) begin
            checkOutput(on3 ? "idle_pslverr3" : "idle_pslverr", 32'(err), 32'd0);
            checkOutput(on3 ? "idle_prdata3" : "idle_prdata", data, 32'd0);
        end else if ((on3 && q3.size() == 0) || (!on3 && q0.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_pready: actual pready=1 required no response (dut3=%0d cycle %0d)",
                     on3, cycle);
        end else begin
            if (on3) e = q3.pop_front();
            else     e = q0.pop_front();
            checkOutput(on3 ? "resp_cycle3" : "resp_cycle", cycle, e.cyc);
            checkOutput(on3 ? "pslverr3" : "pslverr", 32'(err), 32'(e.err));
            checkOutput(on3 ? "prdata3" : "prdata", data, e.data);
        end
    endtask

    always @(negedge pclk) begin
        if (presetn) begin
            monitorPort(1'b0, apb.pready, apb.pslverr, apb.prdata);
            monitorPort(1'b1, apb3.pready, apb3.pslverr, apb3.prdata);
        end
    end

    // One APB transfer; ack_k/junk_k are access-cycle indices (A0 = 0), exp_lat < 0 means no response.
    task automatic applyStimulus(input bit on3, input logic [11:0] addr, input logic wr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int ack_k, input logic ack_err, input logic [31:0] rdata,
                                 input int junk_k, input logic [3:0] junk_mask,
                                 input bit exp_req, input int exp_lat, input logic exp_err,
                                 input logic [31:0] exp_rdata, input int abort_k);
        logic [1:0] ch;
        logic [3:0] ack_v, err_v, pulse;
        int         a0, extra;
        bit         resp_seen, done;
        exp_t       e;
        ch        = addr[9:8];
        extra     = 0;
        resp_seen = 1'b0;
        done      = 1'b0;
        pulse     = exp_req ? (4'b0001 << ch) : 4'b0000;
        con_rdata0 = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000};
        con_rdata3 = {32'h0BAD_3002, 32'h0BAD_3001, 32'h0BAD_3000};
        if (on3) begin
            if (ch != 2'd3) con_rdata3[ch*32 +: 32] = rdata;
        end else begin
            con_rdata0[ch*32 +: 32] = rdata;
        end
        @(posedge pclk); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; penable = 1'b0;
        if (on3) psel3 = 1'b1;
        else     psel0 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        a0 = cycle;
        if (exp_lat >= 0) begin
            e.cyc = a0 + exp_lat; e.err = exp_err; e.data = exp_rdata;
            if (on3) q3.push_back(e);
            else     q0.push_back(e);
        end
        for (int j = 0; j < 200 && !done; j++) begin
            if (j > 0) begin
                @(posedge pclk); #1;
            end
            if (resp_seen || (exp_lat < 0 && j >= abort_k)) begin
                psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
            end
            ack_v = '0;
            err_v = '0;
            if (j == ack_k) begin
                ack_v[ch] = 1'b1;
                err_v[ch] = ack_err;
            end
            if (j == junk_k) ack_v = ack_v | junk_mask;
            con_ack0 = on3 ? 4'b0 : ack_v;
            con_err0 = on3 ? 4'b0 : err_v;
            con_ack3 = on3 ? ack_v[2:0] : 3'b0;
            con_err3 = on3 ? err_v[2:0] : 3'b0;
            #1;
            if (j == 0) begin
                checkOutput("con_wr", on3 ? 32'(con_wr3) : 32'(con_wr0), wr ? 32'(pulse) : 32'd0);
                checkOutput("con_rd", on3 ? 32'(con_rd3) : 32'(con_rd0), wr ? 32'd0 : 32'(pulse));
                if (exp_req) begin
                    checkOutput("con_addr", on3 ? 32'(con_addr3) : 32'(con_addr0), 32'(addr[7:0]));
                    checkOutput("con_wdata", on3 ? con_wdata3 : con_wdata0, wdata);
                    checkOutput("con_wstrb", on3 ? 32'(con_wstrb3) : 32'(con_wstrb0), 32'(strb));
                end
            end else if (on3 ? ((con_wr3 | con_rd3) != 3'b0) : ((con_wr0 | con_rd0) != 4'b0)) begin
                extra++;
            end
            @(negedge pclk);
            if (on3 ? apb3.pready : apb.pready) resp_seen = 1'b1;
            done = (resp_seen || (exp_lat < 0 && j >= abort_k + 2)) && (j >= ack_k) && (j >= junk_k);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL xfer_timeout: actual no completion required completion (addr 0x%0h)", addr);
        end
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        con_ack0 = '0; con_err0 = '0; con_ack3 = '0; con_err3 = '0;
        checkOutput("extra_pulses", 32'(extra), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        // Hold an access on the bus during reset: no request may leak out.
        paddr = 12'h100; pwrite = 1'b1; psel0 = 1'b1; penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("rst_con_wr", 32'(con_wr0), 32'd0);
        checkOutput("rst_pready", 32'(apb.pready), 32'd0);
        checkOutput("rst_pslverr", 32'(apb.pslverr), 32'd0);
        checkOutput("rst_prdata", apb.prdata, 32'd0);
        checkOutput("rst_err_count", 32'(err_count0), 32'd0);
        checkOutput("rst_pready3", 32'(apb3.pready), 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        presetn = 1'b1;

        applyStimulus(0, 12'h1A4, 1, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0, -1, 4'h0, 1, 2, 0, 32'h0, 0);
        applyStimulus(0, 12'h310, 0, 32'h0, 4'h0, 4, 0, 32'h12345678, -1, 4'h0, 1, 5, 0, 32'h12345678, 0);
        applyStimulus(0, 12'h020, 0, 32'h0, 4'h0, 3, 0, 32'h0F0F1234, 0, 4'b0001, 1, 4, 0, 32'h0F0F1234, 0);
        applyStimulus(0, 12'h2C8, 1, 32'h01020304, 4'h3, 2, 0, 32'h0, 1, 4'b1011, 1, 3, 0, 32'h0, 0);

        applyStimulus(0, 12'h200, 0, 32'h0, 4'h0, 1, 1, 32'h55AA55AA, -1, 4'h0, 1, 2, 1, 32'h0, 0);
        @(posedge pclk); #1;
        checkOutput("err_count_1", 32'(err_count0), 32'd1);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(0, 12'h200, 0, 32'h0, 4'h0, 1, 1, 32'h55AA55AA, -1, 4'h0, 1, 2, 1, 32'h0, 0);
        end
        @(posedge pclk); #1;
        checkOutput("err_count_sat", 32'(err_count0), 32'd255);
        err_clr = 1'b1;
        @(posedge pclk); #1;
        err_clr = 1'b0;
        checkOutput("err_count_clr", 32'(err_count0), 32'd0);

        applyStimulus(0, 12'h1F0, 1, 32'h11112222, 4'hF, 2, 1, 32'h0, -1, 4'h0, 1, 3, 1, 32'h0, 0);
        @(posedge pclk); #1;
        checkOutput("err_count_wr", 32'(err_count0), 32'd1);

        applyStimulus(0, 12'h000, 1, 32'hA0A0A0A0, 4'hF, -1, 0, 32'h0, 70, 4'b0001, 1, 65, 1, 32'h0, 0);
        applyStimulus(0, 12'h104, 0, 32'h0, 4'h0, 64, 0, 32'hA5A55A5A, -1, 4'h0, 1, 65, 0, 32'hA5A55A5A, 0);
        applyStimulus(0, 12'h8C0, 0, 32'h0, 4'h0, -1, 0, 32'h0, -1, 4'h0, 0, 1, 1, 32'h0, 0);
        applyStimulus(0, 12'h400, 1, 32'h0, 4'h0, -1, 0, 32'h0, -1, 4'h0, 0, 1, 1, 32'h0, 0);

        applyStimulus(1, 12'h3A0, 0, 32'h0, 4'h0, -1, 0, 32'h0, -1, 4'h0, 0, 1, 1, 32'h0, 0);
        applyStimulus(1, 12'h8C0, 1, 32'h0, 4'h0, -1, 0, 32'h0, -1, 4'h0, 0, 1, 1, 32'h0, 0);
        applyStimulus(1, 12'h2F0, 0, 32'h0, 4'h0, 3, 0, 32'hCAFEF00D, 1, 4'b0001, 1, 4, 0, 32'hCAFEF00D, 0);

        applyStimulus(0, 12'h110, 0, 32'h0, 4'h0, -1, 0, 32'h0, 5, 4'b0010, 1, -1, 0, 32'h0, 3);
        applyStimulus(0, 12'h3FC, 1, 32'h76543210, 4'h8, 1, 0, 32'h0, -1, 4'h0, 1, 2, 0, 32'h0, 0);

        // Reset while the bridge waits on channel 1, with the access still held on the bus.
        @(posedge pclk); #1;
        paddr = 12'h140; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        checkOutput("wrst_con_rd", 32'(con_rd0), 32'd0);
        checkOutput("wrst_pready", 32'(apb.pready), 32'd0);
        checkOutput("wrst_pslverr", 32'(apb.pslverr), 32'd0);
        checkOutput("wrst_prdata", apb.prdata, 32'd0);
        checkOutput("wrst_err_count", 32'(err_count0), 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        presetn = 1'b1;
        applyStimulus(0, 12'h244, 0, 32'h0, 4'h0, 2, 0, 32'h600DD00D, -1, 4'h0, 1, 3, 0, 32'h600DD00D, 0);

        repeat (3) @(posedge pclk);
        #1;
        checkOutput("q0_left", 32'(q0.size()), 32'd0);
        checkOutput("q3_left", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_conduit_bridge.md
# apb_conduit_bridge

Multi-channel APB completer bridge: decodes each APB transfer onto one of NUM_CH conduit channels and issues a single-cycle read or write request. It then waits for that channel's acknowledge and completes the APB transfer with registered pready/prdata/pslverr. Unlike the single-conduit adapter it replaces, it adds address-region decode, a shared request/response FSM, a per-transfer timeout that converts a hung channel into pslverr, and a saturating error counter. It sits between the APB interconnect and a bank of register-file/peripheral conduits.

## Interface
- D_WIDTH, 32, data width (multiple of 8)
- A_WIDTH, 12, APB address width
- NUM_CH, 4, number of conduit channels (1..16)
- CH_A_WIDTH, 8, per-channel address width; channel index = paddr[CH_A_WIDTH +: CI_W], CI_W = max(1,$clog2(NUM_CH)); requires CH_A_WIDTH+CI_W <= A_WIDTH
- TIMEOUT, 64, wait cycles before timeout error (0 = timeout disabled)

Ports:
- pclk  in  1  clock; single clock domain
- presetn  in  1  reset; synchronous, active-low
- paddr  in  A_WIDTH  APB address
- psel, penable, pwrite  in  1 each  APB control
- pwdata  in  D_WIDTH  write data
- pstrb  in  D_WIDTH/8  write strobes
- pready  out  1  registered transfer-complete
- prdata  out  D_WIDTH  registered read data
- pslverr  out  1  registered error, valid only with pready
- con_wr  out  NUM_CH  one-hot write request pulse
- con_rd  out  NUM_CH  one-hot read request pulse
- con_addr  out  CH_A_WIDTH  paddr[CH_A_WIDTH-1:0], shared
- con_wdata  out  D_WIDTH  pwdata, shared
- con_wstrb  out  D_WIDTH/8  pstrb, shared
- con_ack  in  NUM_CH  per-channel completion
- con_err  in  NUM_CH  per-channel error, sampled with con_ack
- con_rdata  in  NUM_CH*D_WIDTH  per-channel read data, slice ch*D_WIDTH, sampled with con_ack
- err_clr  in  1  clears err_count
- err_count  out  8  saturating count of pslverr responses

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when psel && penable: latch channel index ch, pwrite; if ch >= NUM_CH or any paddr bit above CH_A_WIDTH+CI_W set -> decode error, go RESP with err=1, no request. Otherwise assert con_wr[ch] (pwrite) or con_rd[ch] (!pwrite) combinationally for this cycle only; clear timer; go WAIT.
- WAIT: sample con_ack[ch] only (other channels' acks ignored). On ack: err=con_err[ch]; if read and !con_err[ch], capture rdata=con_rdata slice; go RESP. Else if TIMEOUT!=0 and timer==TIMEOUT-1: err=1, go RESP. Else timer++.
- RESP: pready=1, pslverr=err, prdata=captured data (0 for writes or any error); next cycle IDLE, pready/pslverr/prdata return to 0.
- Abort: psel low in WAIT (protocol violation) -> IDLE, no response; late ack ignored.
- Acks in IDLE/RESP ignored. Requests never issued outside IDLE, so at most one outstanding.
- err_count: +1 each RESP cycle with err=1, saturates at 255; err_clr has priority over increment (count becomes 0).
- Timer width $clog2(TIMEOUT+1), never wraps.

## Timing
- Reset (presetn=0 at posedge): state IDLE, pready=0, pslverr=0, prdata=0, err_count=0, timer=0; con_wr/con_rd=0 while in reset. Reset mid-transfer drops the transfer without response.
- Setup cycle S, first access cycle A0: request pulse in A0. Earliest ack in A1, pready=1 in A2 -> minimum 3 access cycles. Decode error: pready in A1.
- Ack arriving k cycles after A0 -> pready in A(k+1).
- Timeout: no ack -> pready/pslverr=1 in A(TIMEOUT+1).
- Ack in same cycle as timer==TIMEOUT-1: ack wins, err=con_err[ch].
- Back-to-back: new setup may follow RESP cycle directly; IDLE accepts access the cycle after RESP.

## Test plan
- Write ch1 (paddr=0x1A4, pwdata=0xDEADBEEF, pstrb=0xF), con_ack[1] in A1 -> con_wr=4'b0010 one cycle in A0, con_addr=0xA4, pready=1 pslverr=0 in A2.
- Read ch3 (paddr=0x310), ack in A4 with con_rdata slice=0x12345678 -> prdata=0x12345678 with pready in A5, 0 the cycle after.
- Read ch2 with con_ack[2]&con_err[2] -> pslverr=1, prdata=0, err_count=1; repeat 300 times -> err_count saturates at 255; err_clr -> 0.
- TIMEOUT=64, write ch0, no ack -> pready&pslverr in A65; ack on ch0 in A70 ignored, no con_* pulses.
- NUM_CH=3, access paddr=0x3xx or 0x8xx -> no request pulse, pslverr=1 in A1; con_ack[0] asserted during a ch2 transfer -> ignored.
- presetn=0 during WAIT -> all outputs 0, next transfer completes normally.
